pipelined_cla_addsub: RTL and testbench



---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_group.sv | 42 ++++
 rtl/pipelined_cla_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor: op encoding and
// saturation bound helper (used only when PIPELINED_CLA_SAT_EN is defined).
package cla_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int SAT_MAXW = 256;

   // Returns max positive (neg=0) or min negative (neg=1) for a w-bit signed value.
   function automatic logic [SAT_MAXW-1:0] sat_val(input int w, input logic neg);
      logic [SAT_MAXW-1:0] r;
      r = '0;
      for (int i = 0; i < SAT_MAXW; i++) begin
         if (i < w - 1)       r[i] = ~neg;
         else if (i == w - 1) r[i] = neg;
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group: every carry is a flat
// sum-of-products of generate/propagate terms and the group carry-in.
module cla_group #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;
   logic             term;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      term = 1'b0;
      c[0] = cin;
      for (int i = 0; i < BLOCK; i++) begin
         // c[i+1] = cin&P[i:0] | OR_j ( g[j] & P[i:j+1] )
         term = cin;
         for (int j = 0; j <= i; j++) term = term & p[j];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign sum   = p ^ c[BLOCK-1:0];
   assign cout  = c[BLOCK];
   assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined signed CLA adder/subtractor, one register rank per CLA group plus a
// registered result/flag stage. Optional saturation: define PIPELINED_CLA_SAT_EN.
//
// Handshake: a beat moves on in_valid && in_ready, and leaves on
// out_valid && out_ready. When out_valid && !out_ready the whole pipeline
// (bubbles included) freezes and in_ready is low; otherwise it advances.
module pipelined_cla_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NSTG = WIDTH / BLOCK;
   localparam int L    = NSTG - 1;

   // Stage k register holds: sum bits below group k, untouched operand bits
   // from group k upward, and the carry into group k.
   logic [WIDTH-1:0] a_q [NSTG];
   logic [WIDTH-1:0] a_d [NSTG];
   logic [WIDTH-1:0] b_q [NSTG];
   logic [WIDTH-1:0] b_d [NSTG];
   logic [NSTG-1:0]  c_q, c_d;
   logic [NSTG-1:0]  v_q, v_d;

   logic [BLOCK-1:0] gs [NSTG];
   logic [NSTG-1:0]  gco;
   logic [NSTG-1:0]  gcm;

   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic             out_valid_q, out_valid_d;
   logic             out_cout_q, out_cout_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_zero_q, out_zero_d;
   logic             stall;
   logic             accept;

`ifdef PIPELINED_CLA_SAT_EN
   logic [SAT_MAXW-1:0] sat_w;
`endif

   for (genvar k = 0; k < NSTG; k++) begin : g_stage
      cla_group #(.BLOCK(BLOCK)) u_grp (
         .a    (a_q[k][k*BLOCK +: BLOCK]),
         .b    (b_q[k][k*BLOCK +: BLOCK]),
         .cin  (c_q[k]),
         .sum  (gs[k]),
         .cout (gco[k]),
         .c_msb(gcm[k])
      );
   end

   always_comb begin
      stall  = out_valid_q && !out_ready;
      accept = in_valid && !stall;

      a_d[0] = in_a;
      b_d[0] = (in_op == OP_SUB) ? ~in_b : in_b;
      c_d[0] = (in_op == OP_SUB) ? ~in_cin : in_cin;
      v_d[0] = accept;
      for (int k = 1; k < NSTG; k++) begin
         a_d[k] = a_q[k-1];
         a_d[k][(k-1)*BLOCK +: BLOCK] = gs[k-1];
         b_d[k] = b_q[k-1];
         c_d[k] = gco[k-1];
         v_d[k] = v_q[k-1];
      end

      out_valid_d = v_q[L];
      out_sum_d   = a_q[L];
      out_sum_d[L*BLOCK +: BLOCK] = gs[L];
      out_cout_d  = gco[L];
      out_ovf_d   = gco[L] ^ gcm[L];
`ifdef PIPELINED_CLA_SAT_EN
      // Direction of overflow follows the sign of A for both add and sub.
      sat_w = sat_val(WIDTH, a_q[L][WIDTH-1]);
      if (out_ovf_d) out_sum_d = sat_w[WIDTH-1:0];
`endif
      out_zero_d  = (out_sum_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
         c_q         <= '0;
         v_q         <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_zero_q  <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < NSTG; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
         end
         c_q         <= c_d;
         v_q         <= v_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign in_ready  = !stall;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH=32, BLOCK=8); honours
// PIPELINED_CLA_SAT_EN for the expected saturated results.
module tb_pipelined_cla_addsub;

   localparam int W = 32;
   localparam int B = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         out_zero;

   pipelined_cla_addsub #(.WIDTH(W), .BLOCK(B)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: {zero, ovf, cout, sum}
   logic [W+2:0] exp_q[$];
   int n_chk  = 0;
   int n_err  = 0;
   int n_in   = 0;
   int n_out  = 0;
   int n_drop = 0;
   bit rand_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact signed result in 64-bit arithmetic, then wrap or saturate.
   function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic op);
      longint sa, sb, r, maxp, minn;
      logic [W:0]   ext;
      logic [W-1:0] s;
      logic         ovf;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      maxp = (64'sd1 <<< (W - 1)) - 1;
      minn = -(64'sd1 <<< (W - 1));
      if (op == 1'b0) begin
         r   = sa + sb + longint'(cin);
         ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end else begin
         r   = sa - sb - longint'(cin);
         ext = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cin};
      end
      ovf = (r > maxp) || (r < minn);
      s   = ext[W-1:0];
`ifdef PIPELINED_CLA_SAT_EN
      if (ovf) s = a[W-1] ? W'(minn) : W'(maxp);
`endif
      return {(s == '0), ovf, ext[W], s};
   endfunction

   // driver: holds the beat until accepted, bounded
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic op);
      int  n;
      bit  done;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_op = op;
      n = 0; done = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(a, b, cin, op));
            n_in++;
            done = 1;
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 64'd0, 64'd1);
   endtask

   // pins the model against a hand-computed result, then sends the beat
   task automatic vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic op, input logic [W-1:0] es,
                      input logic ec, input logic eo, input logic ez);
      chk({"model_", name}, 64'(model(a, b, cin, op)), 64'({ez, eo, ec, es}));
      send(a, b, cin, op);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // compare process: every beat on the output is checked against the queue
   // front; while stalled the same front must still be shown.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            chk("result", 64'({out_zero, out_ovf, out_cout, out_sum}), 64'(exp_q[0]));
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_out++;
            end else begin
               chk("in_ready_stall", 64'(in_ready), 64'd0);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0;
      out_ready = 1'b1; rand_done = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_flags", 64'({out_sum, out_cout, out_ovf, out_zero}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // latency: out_valid rises exactly 4 edges after the accept edge
      vec("add_5_3", 32'h5, 32'h3, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         chk("latency", 64'(out_valid), 64'(i == 4));
      end
      drain();

      vec("add_carry", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      vec("sub_0_1", 32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
`ifdef PIPELINED_CLA_SAT_EN
      vec("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      vec("sub_ovf", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
      vec("add_neg_ovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
`else
      vec("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      vec("sub_ovf", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      vec("add_neg_ovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
`endif
      vec("add_cin", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0);
      vec("sub_borrow", 32'hA, 32'h3, 1'b1, 1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
      vec("sub_equal", 32'h5, 32'h5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      drain();

      // backpressure: 8 back-to-back beats with a 5-cycle out_ready gap
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(32'h01010101 * (i + 1), 32'h00FF00FF + i, i[0], i[1]);
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // reset mid-flight, with the first beat parked at the stalled output
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(32'h100 + i, 32'h20, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(out_valid), 64'd0);
      chk("async_reset_sum", 64'(out_sum), 64'd0);
      n_drop += exp_q.size();
      exp_q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_stale_beat", 64'(out_valid), 64'd0);
      end
      vec("post_reset", 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         chk("post_reset_latency", 64'(out_valid), 64'(i == 4));
      end
      drain();

      // random add/sub beats with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [W-1:0] ra, rb;
               ra = $urandom();
               rb = $urandom();
               if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
               if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 2));
               send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      chk("beat_count", 64'(n_out + n_drop), 64'(n_in));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
